// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and phase type for the Trivium state engine.
// Tap positions are 1-based Trivium indices; bit s_i lives at vector index i-1.
package trivium_pkg;

    localparam int STATE_W     = 288;
    localparam int KEY_W       = 80;
    localparam int IV_W        = 80;
    localparam int INIT_ROUNDS = 1152;
    localparam int CNT_W       = 11;

    localparam int T_A66  = 66;
    localparam int T_A93  = 93;
    localparam int T_A91  = 91;
    localparam int T_A92  = 92;
    localparam int T_B171 = 171;
    localparam int T_B162 = 162;
    localparam int T_B177 = 177;
    localparam int T_B175 = 175;
    localparam int T_B176 = 176;
    localparam int T_C264 = 264;
    localparam int T_C243 = 243;
    localparam int T_C288 = 288;
    localparam int T_C286 = 286;
    localparam int T_C287 = 287;
    localparam int T_A69  = 69;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        INIT = 2'd1,
        DONE = 2'd2
    } phase_t;

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: next state plus the keystream bit of the
// current (pre-update) state.
module trivium_round
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    output logic [STATE_W-1:0] o_state,
    output logic               o_z
);

    logic w_t1;
    logic w_t2;
    logic w_t3;

    assign w_t1 = i_state[T_A66-1] ^ i_state[T_A93-1]
                ^ (i_state[T_A91-1] & i_state[T_A92-1]) ^ i_state[T_B171-1];
    assign w_t2 = i_state[T_B162-1] ^ i_state[T_B177-1]
                ^ (i_state[T_B175-1] & i_state[T_B176-1]) ^ i_state[T_C264-1];
    assign w_t3 = i_state[T_C243-1] ^ i_state[T_C288-1]
                ^ (i_state[T_C286-1] & i_state[T_C287-1]) ^ i_state[T_A69-1];

    assign o_z = i_state[T_A66-1] ^ i_state[T_A93-1] ^ i_state[T_B162-1]
               ^ i_state[T_B177-1] ^ i_state[T_C243-1] ^ i_state[T_C288-1];

    // Each register shifts toward higher indices, feedback enters at its first bit.
    assign o_state[92:0]    = {i_state[91:0],    w_t3};
    assign o_state[176:93]  = {i_state[175:93],  w_t1};
    assign o_state[287:177] = {i_state[286:177], w_t2};

endmodule

// File: rtl/trivium_init_core.sv
// Trivium key/IV load and warm-up engine; exposes the full state on STRM.
// Define TRIVIUM_KEYSTREAM_EN to keep clocking rounds in DONE and emit z/z_valid.
module trivium_init_core #(
    parameter int INIT_ROUNDS = trivium_pkg::INIT_ROUNDS,
    parameter int STATE_W     = trivium_pkg::STATE_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [trivium_pkg::KEY_W-1:0] KEY,
    input  logic [trivium_pkg::IV_W-1:0]  IV,
`ifdef TRIVIUM_KEYSTREAM_EN
    output logic                          z,
    output logic                          z_valid,
`endif
    output logic [STATE_W-1:0]            STRM
);

    import trivium_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(INIT_ROUNDS - 1);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    phase_t             r_phase;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_load;
    logic               w_z;

    // Key in s1..s80, IV in s94..s173, constant ones in s286..s288.
    assign w_load = {3'b111, 108'd0, 4'd0, IV, 13'd0, KEY};

    trivium_round u_round (
        .i_state (r_state),
        .o_state (w_next),
        .o_z     (w_z)
    );

`ifdef TRIVIUM_KEYSTREAM_EN
    logic r_z;
    logic r_zv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_phase <= LOAD;
            r_z     <= 1'b0;
            r_zv    <= 1'b0;
        end else begin
            case (r_phase)
                LOAD: begin
                    r_state <= w_load;
                    r_phase <= INIT;
                end
                INIT: begin
                    r_state <= w_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ROUND) r_phase <= DONE;
                end
                DONE: begin
                    r_state <= w_next;
                    r_z     <= w_z;
                    r_zv    <= 1'b1;
                end
                default: r_phase <= LOAD;
            endcase
        end
    end

    assign z       = r_z;
    assign z_valid = r_zv;
`else
    logic w_z_idle;
    assign w_z_idle = w_z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_phase <= LOAD;
        end else begin
            case (r_phase)
                LOAD: begin
                    r_state <= w_load;
                    r_phase <= INIT;
                end
                INIT: begin
                    r_state <= w_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ROUND) r_phase <= DONE;
                end
                DONE: r_state <= r_state;
                default: r_phase <= LOAD;
            endcase
        end
    end
`endif

    assign STRM = r_state;

endmodule

// File: tb/tb_trivium_init_core.sv
// Scoreboard bench for trivium_init_core against a bit-array Trivium model.
module tb_trivium_init_core;

    logic         clk = 1'b0;
    logic         reset;
    logic [79:0]  KEY;
    logic [79:0]  IV;
    logic [287:0] STRM;
`ifdef TRIVIUM_KEYSTREAM_EN
    logic         z;
    logic         z_valid;
`endif

    trivium_init_core dut (
        .clk     (clk),
        .reset   (reset),
        .KEY     (KEY),
        .IV      (IV),
`ifdef TRIVIUM_KEYSTREAM_EN
        .z       (z),
        .z_valid (z_valid),
`endif
        .STRM    (STRM)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: 1-based bit array, phase and round count.
    logic m[1:288];
    int   m_phase;
    int   m_cnt;
    logic m_z;
    logic m_zv;

    function automatic logic [287:0] model_vec();
        logic [287:0] v;
        for (int i = 1; i <= 288; i++) v[i-1] = m[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 1; i <= 288; i++) m[i] = 1'b0;
        m_phase = 0;
        m_cnt   = 0;
        m_z     = 1'b0;
        m_zv    = 1'b0;
    endtask

    task automatic model_round();
        logic t1, t2, t3;
        t1 = m[66] ^ m[93] ^ (m[91] & m[92]) ^ m[171];
        t2 = m[162] ^ m[177] ^ (m[175] & m[176]) ^ m[264];
        t3 = m[243] ^ m[288] ^ (m[286] & m[287]) ^ m[69];
        for (int i = 93; i >= 2; i--) m[i] = m[i-1];
        m[1] = t3;
        for (int i = 177; i >= 95; i--) m[i] = m[i-1];
        m[94] = t1;
        for (int i = 288; i >= 179; i--) m[i] = m[i-1];
        m[178] = t2;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_clear();
        end else if (m_phase == 0) begin
            for (int i = 1; i <= 288; i++) m[i] = 1'b0;
            for (int i = 1; i <= 80; i++) m[i] = KEY[i-1];
            for (int i = 1; i <= 80; i++) m[93+i] = IV[i-1];
            m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
            m_phase = 1;
        end else if (m_phase == 1) begin
            model_round();
            m_cnt++;
            if (m_cnt == 1152) m_phase = 2;
        end else begin
`ifdef TRIVIUM_KEYSTREAM_EN
            m_z  = m[66] ^ m[93] ^ m[162] ^ m[177] ^ m[243] ^ m[288];
            m_zv = 1'b1;
            model_round();
`endif
        end
    endtask

    logic [287:0] sb_q[$];
    logic [287:0] f1;
    bit           f1_ok = 1'b0;

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        sb_q.push_back(model_vec());
        #1;
        chk(tag, STRM, sb_q.pop_front());
`ifdef TRIVIUM_KEYSTREAM_EN
        chk({tag, "_z"}, {287'd0, z}, {287'd0, m_z});
        chk({tag, "_zv"}, {287'd0, z_valid}, {287'd0, m_zv});
`endif
    endtask

    task automatic run(input int n, input bit chg);
        for (int e = 1; e <= n; e++) begin
            step("edge");
            if (e == 1153) begin
                if (f1_ok) chk("final1152", STRM, f1);
                else begin
                    f1    = model_vec();
                    f1_ok = 1'b1;
                end
            end
`ifndef TRIVIUM_KEYSTREAM_EN
            if (e > 1153 && f1_ok) chk("hold", STRM, f1);
`endif
            if (chg) begin
                KEY = {$urandom, $urandom, 16'($urandom)};
                IV  = {$urandom, $urandom, 16'($urandom)};
            end
        end
    endtask

    task automatic do_reset(input int edges);
        reset = 1'b1;
        model_clear();
        #1;
        chk("rst_async", STRM, 288'd0);
        for (int i = 0; i < edges; i++) step("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [79:0]  key_r, iv_r;
    logic [287:0] exp_v;

    initial begin
        reset = 1'b1;
        KEY   = '0;
        IV    = 80'h0000123456789abcdef;
        model_clear();
        #1;
        do_reset(2);

        // Load pattern from the spec's IV with zero key.
        step("load");
        exp_v = '0;
        exp_v[172:93]  = IV;
        exp_v[287:285] = 3'b111;
        chk("load_const", STRM, exp_v);

        // All-zero key/IV: after one round only s287,s288 remain set.
        IV = '0;
        do_reset(1);
        step("load0");
        step("round1");
        exp_v = '0;
        exp_v[287:286] = 2'b11;
        chk("round1_const", STRM, exp_v);

        // Random key/IV: full run, golden state captured at round 1152.
        key_r = {$urandom, $urandom, 16'($urandom)};
        iv_r  = {$urandom, $urandom, 16'($urandom)};
        KEY = key_r; IV = iv_r;
        do_reset(1);
        run(2000, 1'b0);

        // Inputs churning after load must not disturb the result.
        KEY = key_r; IV = iv_r;
        do_reset(1);
        step("load_chg");
        KEY = ~key_r; IV = ~iv_r;
        run(1199, 1'b1);
        if (f1_ok) begin
            f1_ok = 1'b0;
            KEY = key_r; IV = iv_r;
            do_reset(1);
            run(1200, 1'b0);
        end

        // Reset mid-INIT clears at once; a fresh load must reach the same state.
        KEY = key_r; IV = iv_r;
        do_reset(1);
        run(500, 1'b0);
        @(negedge clk);
        do_reset(0);
        #1;
        chk("rst_mid", STRM, 288'd0);
        run(1200, 1'b0);

        // Sub-cycle reset pulse while DONE.
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_short", STRM, 288'd0);
        run(3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
